team_06_i2c_effect_cmd: RTL
===========================

// Module: team_06_i2c_effect_cmd
//
// PURPOSE
// - Upstream stage of the team_06 I2C transmitter.
// - Watches the selected audio-effect code and waits until it settles (debounce/stability filter).
// - Frames each new settled effect as a 3-byte I2C write command: device addr, register, data.
// - Buffers commands in a small FIFO and presents bytes one at a time over a valid/ready
//   handshake to the I2C bit-level master.
//
// PARAMETERS
// - EFFECT_W       4       width of effect code (max 8)
// - DEV_ADDR       7'h3C   7-bit I2C target address
// - REG_ADDR       8'h01   target register receiving the effect code
// - SETTLE_CYCLES  1024    clk cycles the effect must hold before it is accepted (>=2)
// - FIFO_DEPTH     4       queued commands (power of 2, >=2)
//
// PORTS
// - clk         in   1         system clock
// - nrst        in   1         synchronous active-low reset
// - effect      in   EFFECT_W  current effect selection (asynchronous to clk)
// - tx_byte     out  8         byte offered to the I2C master
// - tx_valid    out  1         tx_byte/tx_start/tx_stop valid
// - tx_ready    in   1         master accepts byte this cycle
// - tx_start    out  1         first byte of a transaction (master issues START first)
// - tx_stop     out  1         last byte of a transaction (master issues STOP after)
// - busy        out  1         FIFO non-empty or transaction in progress
// - overflow    out  1         sticky: a queued command was overwritten; cleared only by reset
//
// BEHAVIOUR
// - Reset: nrst sampled low at posedge clk. All registers cleared.
//   - Outputs: tx_valid=0, tx_byte=0, tx_start=0, tx_stop=0, busy=0, overflow=0.
//   - FSM returns to IDLE. The FIFO empties.
//   - last_sent = 0, so effect 0 at power-up is never sent.
//   - Reset mid-transaction aborts it with no further bytes; the master owns bus recovery.
// - Input path:
//   - effect passes through a 2-flop synchronizer.
//   - The settle counter clears on any change of the synchronized value, otherwise increments.
//   - The counter saturates at SETTLE_CYCLES-1.
// - Accept:
//   - Fires on the cycle the counter reaches SETTLE_CYCLES-1 and the value != last_sent.
//   - On accept, push the value and set last_sent to it.
//   - One accept per settle event; saturation does not re-fire.
// - FIFO full on accept:
//   - Overwrite the newest entry (latest effect wins) and set overflow.
//   - Push and pop in the same cycle while full is a normal push+pop; overflow is not set.
// - FSM states and outputs:
//   - IDLE: exits to ADDR when the FIFO is not empty.
//   - ADDR: tx_byte={DEV_ADDR,1'b0}, tx_start=1.
//   - REG: tx_byte=REG_ADDR.
//   - DATA: tx_byte=zero-extended effect code, tx_stop=1.
//   - Each byte state asserts tx_valid and advances on the cycle tx_valid&&tx_ready.
//   - DATA handshake pops the FIFO and returns to IDLE.
// - Handshake rules:
//   - While tx_valid && !tx_ready, tx_byte, tx_start and tx_stop hold stable.
//   - tx_valid never drops until the handshake completes.
//   - tx_start and tx_stop are 0 whenever tx_valid=0.
// - Latency:
//   - A stable effect is pushed 2 (sync) + SETTLE_CYCLES cycles after it changes.
//   - The FIFO head is read directly, not through a registered read.
//   - With IDLE and the FIFO empty, tx_valid rises 1 cycle after the push.
//   - Back-to-back commands: IDLE lasts exactly 1 cycle between transactions.
// - The FIFO entry is read in DATA, at pop time. An overwrite of the head during an active
//   transaction is not possible, because overwrite targets the tail and depth >= 2.
//
// CONFIGURATION
// - Macro CMD_CHECKSUM_EN.
// - Defined:
//   - A 4th state CSUM follows DATA: tx_byte = REG_ADDR ^ data byte, tx_stop=1.
//   - DATA has tx_stop=0. The FIFO pops on the CSUM handshake.
// - Undefined: the 3-byte frame above; the CSUM state is absent.
//
// STRUCTURE
// - Package team_06_i2c_pkg holds:
//   - the FSM state enum (IDLE, ADDR, REG, DATA, CSUM);
//   - the I2C write-bit constant;
//   - frame length constants, so the I2C master can share them.
// - Sub-module team_06_sync_fifo: parameterized width/depth.
//   - Ports: push, pop, overwrite-on-full, head, empty, full.
// - The synchronizer, settle counter and FSM live in this module.
//
// TESTING
// - Reset, effect=0 held 5000 cycles -> tx_valid stays 0, busy=0.
// - Sequence:
//   - Stimulus: effect 0->5, held; tx_ready=1.
//   - Response: bytes 0x78 (start=1), 0x01, 0x05 (stop=1).
//   - The first tx_valid comes 2+SETTLE_CYCLES+1 cycles after the change.
// - Glitch:
//   - Stimulus: effect=3 for 500 cycles, then 7 held.
//   - Response: only a 7 frame is sent; no 3 frame.
// - Backpressure:
//   - Stimulus: tx_ready=0 for 20 cycles during REG.
//   - Response: tx_byte=0x01 and tx_valid stay stable, then the frame completes.
// - Overflow:
//   - Stimulus: tx_ready=0; settle 1,2,3,4,5,6 in turn.
//   - Response: overflow=1; on release the frames sent are 1,2,3,6.
// - Checksum:
//   - Stimulus: CMD_CHECKSUM_EN defined, effect=5.
//   - Response: 4th byte 0x04 with stop=1; DATA has stop=0.
//   - Also: nrst low mid-REG -> tx_valid=0 the next cycle.

Source files
------------

// File: rtl/team_06_i2c_effect_cmd_pkg.sv
// Shared definitions for the team_06 I2C transmitter: command FSM states,
// the I2C write-direction bit and frame lengths (also used by the bit-level
// master). Frame length depends on macro CMD_CHECKSUM_EN.
package team_06_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    REG  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } cmd_state_t;

  // R/W bit appended to the 7-bit address; 0 selects a write
  localparam logic I2C_WR_BIT = 1'b0;

  localparam int FRAME_LEN_3B = 3;
  localparam int FRAME_LEN_4B = 4;
`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_4B;
`else
  localparam int FRAME_LEN = FRAME_LEN_3B;
`endif

endpackage

// File: rtl/team_06_i2c_effect_cmd_if.sv
// Byte-level valid/ready link from the command framer to the I2C bit master.
// master = byte source (framer), slave = byte sink (bit-level master).
interface team_06_i2c_effect_cmd_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_start;
  logic       tx_stop;

  modport master (output tx_byte, output tx_valid, output tx_start,
                  output tx_stop, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, input tx_start,
                  input tx_stop, output tx_ready);
endinterface

// File: rtl/team_06_i2c_effect_cmd_fifo.sv
// Small synchronous FIFO with combinational head read. When ovr_en is set,
// a push into a full FIFO (without a simultaneous pop) replaces the newest
// entry instead of being dropped.
module team_06_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic             ovr_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx, ovr_idx;
  logic             do_pop, do_push, do_ovr;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign ovr_idx = wr_idx - ONE;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign do_ovr  = push && full && !do_pop && ovr_en;

  // pointer update and storage write (normal push or newest-entry overwrite)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (do_ovr) begin
        mem[ovr_idx] <= din;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/team_06_i2c_effect_cmd.sv
// Effect-code command framer: synchronizes and debounces the effect input,
// queues each newly settled code and sends it as an I2C write frame
// (addr, register, data[, checksum when CMD_CHECKSUM_EN is defined]).
module team_06_i2c_effect_cmd
  import team_06_i2c_pkg::*;
#(
  parameter int         EFFECT_W      = 4,
  parameter logic [6:0] DEV_ADDR      = 7'h3C,
  parameter logic [7:0] REG_ADDR      = 8'h01,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [EFFECT_W-1:0]           effect,
  team_06_i2c_effect_cmd_if.master      tx,
  output logic                          busy,
  output logic                          overflow
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(SETTLE_CYCLES - 2);
  localparam cmd_state_t LAST_ST = (FRAME_LEN == FRAME_LEN_4B) ? CSUM : DATA;

  logic [EFFECT_W-1:0] sync1, sync2, prev, last_sent, head;
  logic [CNT_W-1:0]    cnt;
  logic                changed, accept, pop, empty, full;
  logic [7:0]          data_byte;
  cmd_state_t          state;

  // accept on the edge where the counter steps onto its saturation value,
  // so a saturated counter never re-fires
  assign changed   = (sync2 != prev);
  assign accept    = !changed && (cnt == CNT_ARM) && (sync2 != last_sent);
  assign pop       = tx.tx_valid && tx.tx_ready && (state == LAST_ST);
  assign data_byte = 8'(head);
  assign busy      = !empty || (state != IDLE);

  // input synchronizer, settle counter and last-accepted value
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      cnt       <= '0;
      last_sent <= '0;
    end else begin
      sync1 <= effect;
      sync2 <= sync1;
      prev  <= sync2;
      if (changed)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (accept) last_sent <= sync2;
    end
  end

  // sticky flag: an accepted command replaced the newest queued entry
  always_ff @(posedge clk) begin
    if (!nrst)                       overflow <= 1'b0;
    else if (accept && full && !pop) overflow <= 1'b1;
  end

  team_06_sync_fifo #(.WIDTH(EFFECT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .nrst   (nrst),
    .push   (accept),
    .pop    (pop),
    .ovr_en (1'b1),
    .din    (sync2),
    .head   (head),
    .empty  (empty),
    .full   (full)
  );

  // frame sequencer with registered byte/flag outputs; the head entry
  // cannot be overwritten while it is being sent (overwrite hits the tail)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_byte  <= 8'h00;
      tx.tx_start <= 1'b0;
      tx.tx_stop  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state       <= ADDR;
          tx.tx_valid <= 1'b1;
          tx.tx_byte  <= {DEV_ADDR, I2C_WR_BIT};
          tx.tx_start <= 1'b1;
          tx.tx_stop  <= 1'b0;
        end
        ADDR: if (tx.tx_ready) begin
          state       <= REG;
          tx.tx_byte  <= REG_ADDR;
          tx.tx_start <= 1'b0;
        end
        REG: if (tx.tx_ready) begin
          state      <= DATA;
          tx.tx_byte <= data_byte;
`ifdef CMD_CHECKSUM_EN
          tx.tx_stop <= 1'b0;
`else
          tx.tx_stop <= 1'b1;
`endif
        end
`ifdef CMD_CHECKSUM_EN
        DATA: if (tx.tx_ready) begin
          state      <= CSUM;
          tx.tx_byte <= REG_ADDR ^ data_byte;
          tx.tx_stop <= 1'b1;
        end
        CSUM: if (tx.tx_ready) begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
          tx.tx_byte  <= 8'h00;
          tx.tx_stop  <= 1'b0;
        end
`else
        DATA: if (tx.tx_ready) begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
          tx.tx_byte  <= 8'h00;
          tx.tx_stop  <= 1'b0;
        end
`endif
        default: begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
          tx.tx_byte  <= 8'h00;
          tx.tx_start <= 1'b0;
          tx.tx_stop  <= 1'b0;
        end
      endcase
    end
  end

endmodule
